// File: rtl/motors_seq.sv
// Sequencer for one motion command: moves the servo, then the XY steppers, then pulses motors_done.
// A leg is skipped when it would not move anything.
module motors_seq #(
  parameter int SERVO_POS_W = 8,
  parameter int PULSE_NUM_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trigger,
  input  logic [SERVO_POS_W-1:0] servo_pos,
  input  logic [PULSE_NUM_W-1:0] pulse_num_x,
  input  logic [PULSE_NUM_W-1:0] pulse_num_y,
  input  logic                   servo_rdy,
  input  logic                   servo_done,
  input  logic                   steppers_rdy,
  input  logic                   steppers_done,
  output logic                   servo_trigger,
  output logic                   steppers_trigger,
  output logic [SERVO_POS_W-1:0] servo_pos_out,
  output logic [PULSE_NUM_W-1:0] pulse_num_x_out,
  output logic [PULSE_NUM_W-1:0] pulse_num_y_out,
  output logic                   motors_rdy,
  output logic                   motors_done
);

  typedef enum logic [2:0] {
    IDLE,
    SERVO_ARM,
    SERVO_WAIT,
    STEP_ARM,
    STEP_WAIT,
    FINISH
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SERVO_POS_W-1:0] last_pos;
  logic                   last_pos_valid;
  logic                   accept;
  logic                   step_fire;
  logic                   cmd_moves;
  logic                   latched_moves;

  assign cmd_moves     = (pulse_num_x != '0) || (pulse_num_y != '0);
  assign latched_moves = (pulse_num_x_out != '0) || (pulse_num_y_out != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    step_fire     = 1'b0;
    servo_trigger = 1'b0;
    motors_rdy    = 1'b0;
    motors_done   = 1'b0;
    case (state)
      IDLE: begin
        motors_rdy = 1'b1;
        if (trigger) begin
          accept = 1'b1;
          if (!last_pos_valid || (servo_pos != last_pos)) begin
            state_nxt = SERVO_ARM;
          end else if (cmd_moves) begin
            state_nxt = STEP_ARM;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      SERVO_ARM: begin
        if (servo_rdy) begin
          servo_trigger = 1'b1;
          state_nxt     = SERVO_WAIT;
        end
      end
      SERVO_WAIT: begin
        if (servo_done) begin
          state_nxt = latched_moves ? STEP_ARM : FINISH;
        end
      end
      STEP_ARM: begin
        if (steppers_rdy) begin
          step_fire = 1'b1;
          state_nxt = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        // A done coinciding with our own trigger pulse belongs to an earlier move.
        if (steppers_done && !steppers_trigger) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        motors_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The steppers trigger is registered, so it lands on the first STEP_WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steppers_trigger <= 1'b0;
      servo_pos_out    <= '0;
      pulse_num_x_out  <= '0;
      pulse_num_y_out  <= '0;
      last_pos         <= '0;
      last_pos_valid   <= 1'b0;
    end else begin
      steppers_trigger <= step_fire;
      if (accept) begin
        servo_pos_out   <= servo_pos;
        pulse_num_x_out <= pulse_num_x;
        pulse_num_y_out <= pulse_num_y;
      end
      if (servo_trigger) begin
        last_pos       <= servo_pos_out;
        last_pos_valid <= 1'b1;
      end
    end
  end

endmodule
